// File: rtl/sample_framer.sv
// Ping-pong frame buffer: gathers decimated samples into FRAME_LEN frames and streams them out over ready/valid.
// Optional dropped-sample counter enabled by defining SAMPLE_FRAMER_DROP_CNT_EN.
module sample_framer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         m_ready,
  output logic                         m_valid,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  input  logic                         ovf_clear,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t                        state_q, state_d;
  logic [1:0]                    full_q;
  logic [1:0]                    set_mask, clr_mask;
  logic                          wr_bank_q;
  logic [IDX_W-1:0]              wr_idx_q;
  logic                          rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]              rd_idx_q, rd_idx_d, rd_idx_nxt, rd_sel;
  logic [IDX_W:0]                rd_addr;
  logic                          xfer;
  logic                          wr_ok, wr_done, drop;

  logic signed [DATA_WIDTH-1:0]  mem [2*FRAME_LEN];
  logic signed [DATA_WIDTH-1:0]  rd_data_p1;

  // The flag is sampled at the start of the cycle, so a same-cycle clear by the reader still drops.
  assign wr_ok    = valid_in & ~full_q[wr_bank_q];
  assign drop     = valid_in &  full_q[wr_bank_q];
  assign wr_done  = wr_ok & (wr_idx_q == LAST_IDX);
  assign set_mask = wr_done ? (2'b01 << wr_bank_q) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      full_q    <= 2'b00;
    end else begin
      full_q <= (full_q & ~clr_mask) | set_mask;
      if (wr_ok) begin
        if (wr_done) begin
          wr_bank_q <= ~wr_bank_q;
          wr_idx_q  <= '0;
        end else begin
          wr_idx_q  <= wr_idx_q + 1'b1;
        end
      end
    end
  end

  // Stage p0 -> p1: synchronous-read frame memory
  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_bank_q, wr_idx_q}] <= data_in;
    rd_data_p1 <= mem[rd_addr];
  end

  // Read address runs one ahead on a transfer so the next sample is ready the following cycle.
  assign rd_idx_nxt = rd_idx_q + 1'b1;
  assign rd_sel     = xfer ? rd_idx_nxt : rd_idx_q;
  assign rd_addr    = {rd_bank_q, rd_sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    clr_mask  = 2'b00;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = FETCH;
      end
      FETCH: begin
        state_d = STREAM;
      end
      STREAM: begin
        m_valid = 1'b1;
        m_last  = (rd_idx_q == LAST_IDX);
        xfer    = m_ready;
        if (xfer) begin
          if (rd_idx_q == LAST_IDX) begin
            clr_mask  = 2'b01 << rd_bank_q;
            rd_bank_d = ~rd_bank_q;
            rd_idx_d  = '0;
            state_d   = IDLE;
          end else begin
            rd_idx_d  = rd_idx_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_data = m_valid ? rd_data_p1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

`ifdef SAMPLE_FRAMER_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 16'd0;
    end else if (drop) begin
      drop_cnt_q <= ovf_clear ? 16'd1 : sat_inc16(drop_cnt_q);
    end else if (ovf_clear) begin
      drop_cnt_q <= 16'd0;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer with FRAME_LEN=8: latency, overflow, backpressure, extremes, reset, ovf_clear.
module tb_sample_framer;

  localparam int DW = 16;
  localparam int FL = 8;
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
  localparam int DROP1 = 1;
`else
  localparam int DROP1 = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst, valid_in, m_ready, ovf_clear;
  logic                 m_valid, m_last, overflow;
  logic signed [DW-1:0] data_in, m_data;
  logic [15:0]          drop_count;

  int checks = 0;
  int errors = 0;
  logic signed [31:0] out_q[$];
  logic signed [31:0] exp_q[$];
  bit                 last_q[$];

  always #5 clk = ~clk;

  sample_framer #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .ovf_clear(ovf_clear), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    valid_in = 1'b1;
    data_in  = v[15:0];
    tick();
    valid_in = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    int k = 0;
    while (out_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check({tag, "_count"}, out_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < out_q.size()) begin
        check($sformatf("%s_data%0d", tag, i), out_q[i], exp_q[i]);
        check($sformatf("%s_last%0d", tag, i), last_q[i], (i % FL) == FL - 1);
      end
    end
    out_q.delete();
    last_q.delete();
    exp_q.delete();
  endtask

  // Transfer capture and hold-under-backpressure watch, sampled on the falling edge.
  logic                 prev_stall = 1'b0;
  logic signed [DW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        out_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    int v4[8] = '{-32768, 32767, -1, 0, 1, 21845, -2, 12345};
    bit found;

    rst = 1'b1; valid_in = 1'b0; data_in = '0; m_ready = 1'b1; ovf_clear = 1'b0;
    tick(); tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    rst = 1'b0;
    tick();

    // Sparse input, one sample every 4 cycles, check latency from the last accept
    for (int v = 1; v <= 7; v++) begin
      send(v);
      repeat (3) tick();
    end
    send(8);
    check("lat_t0_valid", m_valid, 0);
    tick();
    check("lat_t1_valid", m_valid, 0);
    tick();
    check("lat_t2_valid", m_valid, 1);
    check("lat_t2_data", m_data, 1);
    for (int v = 1; v <= 8; v++) exp_q.push_back(v);
    drain("f1", 8);
    check("f1_overflow", overflow, 0);

    // Both banks filled under backpressure, 17th sample dropped
    m_ready = 1'b0;
    for (int v = 1; v <= 16; v++) send(v);
    send(100);
    check("ovf_set", overflow, 1);
    check("ovf_drop_count", drop_count, DROP1);
    check("ovf_stall_valid", m_valid, 1);
    check("ovf_stall_data", m_data, 1);
    m_ready = 1'b1;
    for (int v = 1; v <= 16; v++) exp_q.push_back(v);
    drain("f2", 16);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("clr_overflow", overflow, 0);
    check("clr_drop_count", drop_count, 0);

    // Continuous input with random backpressure across two frames
    for (int v = 32; v < 48; v++) begin
      m_ready = 1'($urandom_range(0, 1));
      send(v);
    end
    repeat (40) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    for (int v = 32; v < 48; v++) exp_q.push_back(v);
    drain("f3", 16);
    check("f3_overflow", overflow, 0);

    // Full-scale values pass through bit-exact
    for (int i = 0; i < 8; i++) begin
      send(v4[i]);
      exp_q.push_back(v4[i]);
    end
    drain("f4", 8);

    // Asynchronous reset while sample 3 is presented
    for (int v = 64; v < 72; v++) send(v);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (m_valid && m_data == 16'sd67) found = 1'b1;
      else tick();
    end
    check("rst5_found", found, 1);
    rst = 1'b1;
    #1;
    check("rst5_valid", m_valid, 0);
    check("rst5_last", m_last, 0);
    check("rst5_data", m_data, 0);
    tick();
    rst = 1'b0;
    out_q.delete();
    last_q.delete();
    tick(); tick(); tick();
    check("rst5_no_stale", m_valid, 0);
    check("rst5_no_out", out_q.size(), 0);
    for (int v = 80; v < 88; v++) begin
      send(v);
      exp_q.push_back(v);
    end
    drain("f5", 8);

    // ovf_clear coinciding with a drop, then a standalone clear
    m_ready = 1'b0;
    for (int v = 96; v < 112; v++) send(v);
    send(112);
    check("c6_overflow", overflow, 1);
    check("c6_drop_count", drop_count, DROP1);
    valid_in = 1'b1;
    data_in = 16'sd113;
    ovf_clear = 1'b1;
    tick();
    valid_in = 1'b0;
    ovf_clear = 1'b0;
    check("c6_coincide_overflow", overflow, 1);
    check("c6_coincide_drop_count", drop_count, DROP1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("c6_clear_overflow", overflow, 0);
    check("c6_clear_drop_count", drop_count, 0);
    m_ready = 1'b1;
    for (int v = 96; v < 112; v++) exp_q.push_back(v);
    drain("f6", 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
# sample_framer

Ping-pong frame buffer sitting directly downstream of the FIR + decimation stage. It collects the single-cycle-valid decimated samples (the `fad_valid_out`/`fad_data_out` pair) into fixed-length frames. It then streams each completed frame out over a ready/valid interface to the next stage, for example the FFT/analysis block. The upstream side cannot stall, so samples that arrive while both banks are occupied are dropped and flagged.

## Interface
- `DATA_WIDTH`, 16, sample width (signed)
- `FRAME_LEN`, 256, samples per frame; power of two, ≥4
- `clk` in 1: system clock
- `rst` in 1: reset; asynchronous, active-high
- `valid_in` in 1: single-cycle sample strobe from decimator
- `data_in` in DATA_WIDTH: signed sample, qualified by `valid_in`
- `m_ready` in 1: downstream ready
- `m_valid` out 1: output sample valid
- `m_data` out DATA_WIDTH: signed output sample
- `m_last` out 1: high with the final sample (index FRAME_LEN-1) of a frame
- `ovf_clear` in 1: single-cycle clear of `overflow`
- `overflow` out 1: sticky, a sample was dropped
- `drop_count` out 16: dropped-sample count (see Configuration)

## Operation
- Storage: 2 banks × FRAME_LEN × DATA_WIDTH, synchronous-read memory (1-cycle read latency), BRAM-inferable.
- Per-bank `full` flag; `wr_bank`, `wr_idx` (log2 FRAME_LEN bits), `rd_bank`, `rd_idx`.
- Write side, on `valid_in`:
  - If `full[wr_bank]`=0: write `data_in` to `[wr_bank][wr_idx]`. If `wr_idx`=FRAME_LEN-1, set `full[wr_bank]`, toggle `wr_bank`, and set `wr_idx`←0. Otherwise increment `wr_idx`.
  - If `full[wr_bank]`=1: drop the sample, set `overflow`, and leave `wr_idx`/`wr_bank` unchanged.
- Read FSM:
  - IDLE: when `full[rd_bank]`, drive read address `rd_idx`=0 and go to FETCH.
  - FETCH: the RAM output becomes valid. Go to STREAM.
  - STREAM: `m_valid`=1 and `m_data`=RAM output. The read address is `rd_idx+1` when `m_valid & m_ready`, otherwise `rd_idx`, so `m_data` holds stable under backpressure. On a transfer with `rd_idx`=FRAME_LEN-1:
    - clear `full[rd_bank]`
    - toggle `rd_bank`
    - set `rd_idx`←0
    - go to IDLE
- `m_last` = STREAM & (`rd_idx`==FRAME_LEN-1).
- Data passes through bit-exact; no arithmetic, no sign change.
- The writer never targets a full bank, so a bank is never written while it is being read.
- `overflow`: set by a drop and cleared by `ovf_clear`. If both happen in the same cycle, set wins.

## Timing
- Reset values:
  - `m_valid`=0, `m_last`=0, `m_data`=0
  - `overflow`=0, `drop_count`=0
  - both `full`=0, all indices 0, `wr_bank`=`rd_bank`=0, FSM=IDLE
- Reset is asynchronous. Asserting it mid-frame or mid-stream discards all buffered data and drops `m_valid` immediately.
- Latency: if the last sample of a frame is accepted at edge t, `m_valid` with sample 0 is high from edge t+2. The bank flag updates at t, IDLE→FETCH at t+1, STREAM at t+2.
- Throughput: one sample per cycle while `m_ready`=1. Between frames, at least 2 idle cycles (IDLE, FETCH).
- Simultaneous events:
  - The writer completing bank A while the reader clears bank B in the same cycle is legal; both flags update.
  - If the reader clears `full[X]` in the same cycle a sample targets bank X, that sample is still dropped; the flag is evaluated at the start of the cycle.
- `m_valid` never deasserts without a transfer, except on reset.

## Configuration
- `SAMPLE_FRAMER_DROP_CNT_EN`
  - Defined: `drop_count` increments on each dropped sample and saturates at 16'hFFFF. It is cleared by `ovf_clear`; if a drop and `ovf_clear` coincide, the result is 1.
  - Undefined: no counter logic is built and `drop_count` is tied to 0. `overflow` behaves identically in both builds.

## Test plan
- Bench uses FRAME_LEN=8, `m_ready`=1, and one input every 4 cycles with values 1..8. Required: `m_data` = 1..8 on consecutive cycles, `m_last` only on 8, first `m_valid` 2 cycles after sample 8 is accepted, `overflow`=0.
- 16 inputs (1..16) with `m_ready`=0, then a 17th input 100, then `m_ready`=1. Required: `overflow`=1, frames 1..8 then 9..16 stream out, 100 is never output, `drop_count`=1 with the macro and 0 without.
- Continuous frame, `m_ready` toggled pseudo-randomly. Required: every sample is output exactly once in order, and `m_data` is stable whenever `m_valid`=1 & `m_ready`=0.
- Input -32768 and 32767 within a frame. Required: output bit-exact.
- Assert `rst` while streaming sample 3 of a frame. Required: `m_valid`=0 immediately. After release, a fresh 8-sample frame streams from sample 0 with no stale data.
- `ovf_clear` in the same cycle as a drop. Required: `overflow` stays 1. A later standalone `ovf_clear` gives `overflow`=0 and `drop_count`=0.
